// File: rtl/mem_bus_decoder_if.sv
// Bus bundle between the picorv32 native memory port, the decoder and its peripheral slots.
// The decoder sits on the slave modport; the CPU/slot side (or a bench) uses master.
interface mem_bus_decoder_if #(
  parameter int NUM_SLAVES = 6
);
  logic                      mem_valid;
  logic [31:0]               mem_addr;
  logic [3:0]                mem_wstrb;
  logic                      mem_ready;
  logic [31:0]               mem_rdata;
  logic [NUM_SLAVES-1:0]     s_cs;
  logic [3:0]                s_wstrb;
  logic [NUM_SLAVES-1:0]     s_ready;
  logic [32*NUM_SLAVES-1:0]  s_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wstrb, s_ready, s_rdata,
    input  mem_ready, mem_rdata, s_cs, s_wstrb
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wstrb, s_ready, s_rdata,
    output mem_ready, mem_rdata, s_cs, s_wstrb
  );
endinterface

// File: rtl/mem_bus_decoder.sv
// Address decoder and response mux from the picorv32 memory port to NUM_SLAVES slots.
// Optional handshake timeout is built only when BUS_TIMEOUT_EN is defined.
module mem_bus_decoder #(
  parameter int                    NUM_SLAVES     = 6,
  parameter int                    SEL_LSB        = 12,
  parameter int                    SEL_BITS       = 4,
  parameter logic [NUM_SLAVES-1:0] FIXED_LAT_MASK = 6'b101111,
  parameter int                    FIXED_LAT      = 1,
  parameter int                    TIMEOUT        = 255,
  parameter logic [31:0]           ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mem_bus_decoder_if.slave       bus,
  output logic                   err_irq,
  output logic [31:0]            err_addr,
  output logic [7:0]             err_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_t;

`ifdef BUS_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [SEL_BITS:0] NUM_SLAVES_W = (SEL_BITS+1)'(NUM_SLAVES);
  localparam logic [7:0]        FIXED_END_W  = 8'(FIXED_LAT - 1);
  localparam logic [7:0]        TIMEOUT_W    = 8'(TIMEOUT);

  state_t                  state_r, state_n_s;
  logic [SEL_BITS-1:0]     sel_q_r, sel_n_s, sel_s;
  logic [7:0]              cnt_r, cnt_n_s;
  logic [31:0]             addr_r, addr_n_s;
  logic [NUM_SLAVES-1:0]   s_cs_r;
  logic                    mem_ready_r;
  logic [31:0]             mem_rdata_r;
  logic                    err_irq_r;
  logic [31:0]             err_addr_r;
  logic [7:0]              err_count_r;
  logic                    unmapped_s;
  logic                    capture_s;
  logic                    err_s;
  logic [31:0]             rdata_sel_s;
  logic                    ready_sel_s;
  logic                    fixed_sel_s;

  function automatic logic [NUM_SLAVES-1:0] onehot(input logic [SEL_BITS-1:0] sel);
    logic [NUM_SLAVES-1:0] oh;
    oh = {NUM_SLAVES{1'b0}};
    for (int i = 0; i < NUM_SLAVES; i++) begin
      oh[i] = (sel == SEL_BITS'(i));
    end
    return oh;
  endfunction

  assign sel_s      = bus.mem_addr[SEL_LSB +: SEL_BITS];
  assign unmapped_s = ({1'b0, sel_s} >= NUM_SLAVES_W);

  // Route the latched slot's data, ready and latency mode.
  always_comb begin
    rdata_sel_s = 32'h0000_0000;
    ready_sel_s = 1'b0;
    fixed_sel_s = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      rdata_sel_s = (sel_q_r == SEL_BITS'(i)) ? bus.s_rdata[32*i +: 32] : rdata_sel_s;
      ready_sel_s = (sel_q_r == SEL_BITS'(i)) ? bus.s_ready[i]         : ready_sel_s;
      fixed_sel_s = (sel_q_r == SEL_BITS'(i)) ? FIXED_LAT_MASK[i]      : fixed_sel_s;
    end
  end

  // Next-state and transaction control.
  always_comb begin
    state_n_s = state_r;
    sel_n_s   = sel_q_r;
    cnt_n_s   = cnt_r;
    addr_n_s  = addr_r;
    capture_s = 1'b0;
    err_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.mem_valid) begin
          sel_n_s  = sel_s;
          addr_n_s = bus.mem_addr;
          cnt_n_s  = 8'd0;
          if (unmapped_s) begin
            state_n_s = ST_RESP;
            err_s     = 1'b1;
          end else begin
            state_n_s = ST_ACCESS;
          end
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        cnt_n_s = (cnt_r == 8'hFF) ? cnt_r : cnt_r + 8'd1;
        // A dropped request abandons the access silently.
        if (!bus.mem_valid) begin
          state_n_s = ST_IDLE;
        end else if (fixed_sel_s) begin
          if (cnt_r == FIXED_END_W) begin
            capture_s = 1'b1;
            state_n_s = ST_RESP;
          end else begin
            state_n_s = ST_ACCESS;
          end
        end else if (ready_sel_s) begin
          capture_s = 1'b1;
          state_n_s = ST_RESP;
        end else if (TIMEOUT_EN && (cnt_r == TIMEOUT_W)) begin
          err_s     = 1'b1;
          state_n_s = ST_RESP;
        end else begin
          state_n_s = ST_ACCESS;
        end
      end
      ST_RESP: begin
        state_n_s = ST_IDLE;
      end
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // State, select, response and error registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      sel_q_r     <= {SEL_BITS{1'b0}};
      cnt_r       <= 8'd0;
      addr_r      <= 32'h0000_0000;
      s_cs_r      <= {NUM_SLAVES{1'b0}};
      mem_ready_r <= 1'b0;
      mem_rdata_r <= 32'h0000_0000;
      err_irq_r   <= 1'b0;
      err_addr_r  <= 32'h0000_0000;
      err_count_r <= 8'd0;
    end else begin
      state_r     <= state_n_s;
      sel_q_r     <= sel_n_s;
      cnt_r       <= cnt_n_s;
      addr_r      <= addr_n_s;
      s_cs_r      <= (state_n_s == ST_ACCESS) ? onehot(sel_n_s) : {NUM_SLAVES{1'b0}};
      mem_ready_r <= (state_n_s == ST_RESP);
      err_irq_r   <= err_s;
      if (err_s) begin
        mem_rdata_r <= ERR_RDATA;
        err_addr_r  <= addr_n_s;
        err_count_r <= (err_count_r == 8'hFF) ? err_count_r : err_count_r + 8'd1;
      end else if (capture_s) begin
        mem_rdata_r <= rdata_sel_s;
      end else begin
        mem_rdata_r <= mem_rdata_r;
      end
    end
  end

  assign bus.s_cs      = s_cs_r;
  assign bus.s_wstrb   = (|s_cs_r) ? bus.mem_wstrb : 4'b0000;
  assign bus.mem_ready = mem_ready_r;
  assign bus.mem_rdata = mem_rdata_r;
  assign err_irq       = err_irq_r;
  assign err_addr      = err_addr_r;
  assign err_count     = err_count_r;

endmodule

// File: doc/mem_bus_decoder.md
Name: mem_bus_decoder

Overview:
- Parametrised address decoder and response mux between the picorv32 native memory port and NUM_SLAVES peripheral slots.
- Replaces hand-written chip-select and ready logic in top-level glue.
- Slot select is taken from a configurable address field.
- Each slot runs either in fixed-latency mode (ROM/RAM style) or ready-handshake mode (UART style).
- Unmapped accesses and optional timeouts complete with an error response, so the CPU never hangs.

Parameters:
NUM_SLAVES, 6, number of slots; legal range 1..2**SEL_BITS
SEL_LSB, 12, lowest address bit of the slot-select field
SEL_BITS, 4, width of the slot-select field
FIXED_LAT_MASK, 6'b101111, bit i = 1: slot i uses fixed latency; bit i = 0: slot i uses its s_ready handshake
FIXED_LAT, 1, cycles a fixed-latency slot needs before its rdata is valid; legal range 1..15
TIMEOUT, 255, handshake cycles allowed before an error response (only with BUS_TIMEOUT_EN)
ERR_RDATA, 32'hDEAD_BEEF, read data returned on an error response

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
mem_valid  in  1  CPU request valid
mem_addr  in  32  CPU address; held stable while mem_valid is high
mem_wstrb  in  4  CPU write strobes; passed unmodified to slaves
mem_ready  out  1  one-cycle completion pulse to CPU
mem_rdata  out  32  read data; valid when mem_ready = 1
s_cs  out  NUM_SLAVES  one-hot slot select
s_wstrb  out  4  mem_wstrb gated by any s_cs bit; 0 otherwise
s_ready  in  NUM_SLAVES  per-slot ready; sampled only for handshake slots
s_rdata  in  32*NUM_SLAVES  flattened read data; slot i occupies bits [32*i+31:32*i]
err_irq  out  1  one-cycle pulse on any error response
err_addr  out  32  address of the most recent error
err_count  out  8  saturating count of error responses

Behaviour:
- Reset, clk and rst_n: the clock is clk; reset is synchronous and active-low on rst_n. While rst_n = 0 at a clock edge:
  - state = IDLE
  - s_cs = 0, mem_ready = 0, err_irq = 0
  - mem_rdata = 0, err_addr = 0, err_count = 0
  - Reset mid-transaction drops the access with no mem_ready.
- FSM states: IDLE, ACCESS, RESP. All outputs are registered or decoded from state; there is no combinational path from mem_valid to mem_ready.
- IDLE, on mem_valid = 1:
  - sel = mem_addr[SEL_LSB+SEL_BITS-1:SEL_LSB]; latch it as sel_q.
  - If sel >= NUM_SLAVES: go to RESP with the error flag set and mem_rdata = ERR_RDATA.
  - Otherwise: clear cnt and go to ACCESS.
- ACCESS:
  - s_cs = onehot(sel_q); cnt increments each cycle, saturating at 255.
  - Fixed slot: when cnt == FIXED_LAT-1, capture the s_rdata slice into mem_rdata and go to RESP.
  - Handshake slot: on the first cycle with s_ready[sel_q] = 1, capture the slice and go to RESP.
  - If mem_valid falls during ACCESS: return to IDLE, no mem_ready, no error.
- RESP:
  - mem_ready = 1 for exactly one cycle, s_cs = 0, then IDLE.
  - On error: err_irq = 1 in the same cycle, err_addr = the latched address, err_count += 1 saturating at 255.
- Latency, with mem_valid first seen at cycle 0:
  - Fixed slot: ACCESS occupies cycles 1..FIXED_LAT; mem_ready at cycle FIXED_LAT+1.
  - Handshake slot: s_ready seen at cycle k gives mem_ready at cycle k+1.
  - Unmapped access: mem_ready at cycle 1.
  - Back-to-back transactions: mem_valid held high in the cycle after RESP starts a new decode in IDLE, giving one dead cycle between accesses.
- s_ready on non-selected slots is ignored. Simultaneous s_ready on several slots is harmless, because only sel_q is sampled.
- mem_rdata holds its value between transactions; it is only updated on capture or error.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- With the macro defined: a handshake slot still in ACCESS when cnt == TIMEOUT goes to RESP with the error flag set and mem_rdata = ERR_RDATA. This response is identical to an unmapped access.
- Without the macro: no timeout logic is built, and handshake slots may wait indefinitely. err_irq, err_addr and err_count then reflect unmapped accesses only.

Test Plan:
- Reset: rst_n = 0 for 2 cycles mid-ACCESS → s_cs = 0 and mem_ready = 0 the next cycle; err_count = 0; no later mem_ready for the dropped access.
- Fixed slot: read 0x0000_0104, slot 0 drives 0x1234_5678, FIXED_LAT = 1 → s_cs = 6'b000001 during cycle 1; mem_ready at cycle 2 with rdata 0x1234_5678.
- Handshake slot: write 0x0000_4000 with wstrb 4'b0001; s_ready[4] rises at cycle 5 → s_wstrb = 4'b0001 during ACCESS; mem_ready exactly at cycle 6, one cycle wide.
- Unmapped: read 0x0000_7000 → mem_ready at cycle 1 with 0xDEAD_BEEF; err_irq pulses once; err_addr = 0x0000_7000; err_count = 1.
- Timeout (BUS_TIMEOUT_EN, TIMEOUT = 255): read slot 4 with s_ready held low → error response with mem_ready at cycle 257. Without the macro, mem_ready stays low for 1000 cycles.
- Back-to-back: two reads of slot 1, with mem_valid high continuously except the RESP-follow cycle → two mem_ready pulses; data is routed correctly; no s_cs overlap.
